// File: rtl/pcpi_fp_sumsq.sv
// PCPI co-processor returning rs1*rs1 + rs2*rs2 in IEEE-754 single precision.
// Uses one shared 24x24 mantissa multiplier. Latency is fixed, and the result truncates toward zero.
//
// state | meaning
// IDLE  | waiting for a matching instruction; hold blocks re-accept after DONE
// SQ_A  | square mantissa of rs1 into term a
// SQ_B  | square mantissa of rs2 into term b
// ADD   | align smaller term, add into 28-bit sum
// NORM  | normalise sum, pack result, raise ready
// DONE  | ready/wr pulse, set hold
module pcpi_fp_sumsq #(
    parameter logic [6:0] OPCODE = 7'b0110011,
    parameter logic [6:0] FUNCT7 = 7'b0000001,
    parameter logic [2:0] FUNCT3 = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    typedef enum logic [2:0] {IDLE, SQ_A, SQ_B, ADD, NORM, DONE} state_t;

    state_t             state;
    logic               hold;
    logic [30:0]        op_a;
    logic [30:0]        op_b;
    logic               spec_nan;
    logic               spec_inf;
    logic signed [9:0]  term_a_exp;
    logic signed [9:0]  term_b_exp;
    logic [26:0]        term_a_man;
    logic [26:0]        term_b_man;
    logic [27:0]        sum;
    logic signed [9:0]  sum_exp;

    logic               match;
    logic               nan_a;
    logic               nan_b;
    logic               inf_a;
    logic               inf_b;
    logic [30:0]        mul_src;
    logic [23:0]        mul_man;
    logic [47:0]        prod;
    logic signed [9:0]  sq_exp;
    logic [26:0]        sq_man;
    logic               sq_zero;
    logic               a_big;
    logic signed [9:0]  big_exp;
    logic signed [9:0]  small_exp;
    logic [26:0]        big_man;
    logic [26:0]        small_man;
    logic [9:0]         diff;
    logic [26:0]        shifted;
    logic [27:0]        sum_next;
    logic [26:0]        norm_man;
    logic signed [9:0]  norm_exp;
    logic [31:0]        result;
    logic               unused_bits;

    assign match = pcpi_valid && (pcpi_insn[6:0] == OPCODE) &&
                   (pcpi_insn[31:25] == FUNCT7) && (pcpi_insn[14:12] == FUNCT3);

    assign nan_a = (&pcpi_rs1[30:23]) && (|pcpi_rs1[22:0]);
    assign nan_b = (&pcpi_rs2[30:23]) && (|pcpi_rs2[22:0]);
    assign inf_a = (&pcpi_rs1[30:23]) && !(|pcpi_rs1[22:0]);
    assign inf_b = (&pcpi_rs2[30:23]) && !(|pcpi_rs2[22:0]);

    // Shared multiplier: operand selected by the squaring state.
    assign mul_src = (state == SQ_B) ? op_b : op_a;
    assign mul_man = {1'b1, mul_src[22:0]};
    assign prod    = mul_man * mul_man;
    assign sq_exp  = $signed({1'b0, mul_src[30:23], 1'b0}) - 10'sd127
                   + $signed({9'b0, prod[47]});
    assign sq_man  = prod[47] ? prod[47:21] : prod[46:20];
    assign sq_zero = (mul_src[30:23] == 8'd0) || (sq_exp <= 10'sd0);

    always_comb begin
        a_big     = (term_a_exp >= term_b_exp);
        big_exp   = a_big ? term_a_exp : term_b_exp;
        small_exp = a_big ? term_b_exp : term_a_exp;
        big_man   = a_big ? term_a_man : term_b_man;
        small_man = a_big ? term_b_man : term_a_man;
        diff      = big_exp - small_exp;
        shifted   = (diff >= 10'd27) ? 27'd0 : (small_man >> diff);
        sum_next  = {1'b0, big_man} + {1'b0, shifted};
    end

    always_comb begin
        norm_man = sum[27] ? sum[27:1] : sum[26:0];
        norm_exp = sum_exp + $signed({9'b0, sum[27]});
        if (spec_nan)
            result = 32'h7FC0_0000;
        else if (spec_inf)
            result = 32'h7F80_0000;
        else if (sum == 28'd0)
            result = 32'h0000_0000;
        else if (norm_exp >= 10'sd255)
            result = 32'h7F80_0000;
        else
            result = {1'b0, norm_exp[7:0], norm_man[25:3]};
    end

    assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7], pcpi_rs1[31], pcpi_rs2[31],
                           prod[19:0], norm_man[26], norm_man[2:0], norm_exp[9:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            spec_nan   <= 1'b0;
            spec_inf   <= 1'b0;
            term_a_exp <= '0;
            term_b_exp <= '0;
            term_a_man <= '0;
            term_b_man <= '0;
            sum        <= '0;
            sum_exp    <= '0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hold       <= 1'b0;
                    pcpi_ready <= 1'b0;
                    pcpi_wr    <= 1'b0;
                    if (match && !hold) begin
                        op_a      <= pcpi_rs1[30:0];
                        op_b      <= pcpi_rs2[30:0];
                        spec_nan  <= nan_a || nan_b;
                        spec_inf  <= inf_a || inf_b;
                        pcpi_wait <= 1'b1;
                        state     <= SQ_A;
                    end
                end
                SQ_A: begin
                    term_a_exp <= sq_zero ? 10'sd0 : sq_exp;
                    term_a_man <= sq_zero ? 27'd0 : sq_man;
                    state      <= SQ_B;
                end
                SQ_B: begin
                    term_b_exp <= sq_zero ? 10'sd0 : sq_exp;
                    term_b_man <= sq_zero ? 27'd0 : sq_man;
                    state      <= ADD;
                end
                ADD: begin
                    sum     <= sum_next;
                    sum_exp <= big_exp;
                    state   <= NORM;
                end
                NORM: begin
                    pcpi_rd    <= result;
                    pcpi_wait  <= 1'b0;
                    pcpi_ready <= 1'b1;
                    pcpi_wr    <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    // Core still drives valid for one cycle after it sees ready.
                    pcpi_ready <= 1'b0;
                    pcpi_wr    <= 1'b0;
                    hold       <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
